// File: rtl/taxi_pkg.sv
// Shared taxi definitions: trip FSM state encodings and speed-class constants,
// used by both taxi_trip_ctrl and the taxi_distance datapath.
package taxi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_SETTLE = 3'd4
  } taxi_state_e;

  localparam logic [1:0] SPEED_NORMAL = 2'd0;
  localparam logic [1:0] SPEED_FAST   = 2'd1;
  localparam logic [1:0] SPEED_FASTER = 2'd2;
  localparam logic [1:0] SPEED_RSVD   = 2'd3;

  // The reserved class is clamped to the fastest defined class.
  function automatic logic [1:0] sat_speed(input logic [1:0] sel);
    if (sel == SPEED_RSVD) begin
      return SPEED_FASTER;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/taxi_btn_debounce.sv
// Button debouncer: one-cycle event after DEBOUNCE_CYCLES consecutive high
// samples that follow a low sample; holding the button gives no repeat.
module taxi_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt_r;
  logic       armed_r;
  logic       evt_r;

  // armed_r stays low out of reset so a button held across release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= 8'd0;
      armed_r <= 1'b0;
      evt_r   <= 1'b0;
    end else if (!btn) begin
      cnt_r   <= 8'd0;
      armed_r <= 1'b1;
      evt_r   <= 1'b0;
    end else if (armed_r && (cnt_r == LAST_CNT)) begin
      cnt_r   <= 8'd0;
      armed_r <= 1'b0;
      evt_r   <= 1'b1;
    end else if (armed_r) begin
      cnt_r   <= cnt_r + 8'd1;
      armed_r <= 1'b1;
      evt_r   <= 1'b0;
    end else begin
      cnt_r   <= cnt_r;
      armed_r <= 1'b0;
      evt_r   <= 1'b0;
    end
  end

  assign evt = evt_r;

endmodule

// File: rtl/taxi_trip_ctrl.sv
// Taxi trip controller: debounced buttons drive the trip FSM, which steers the
// taxi_distance datapath and snapshots the fare when a trip ends.
module taxi_trip_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_end,
  input  logic        btn_pause,
  input  logic        btn_wait,
  input  logic [1:0]  speed_sel,
  input  logic [31:0] distance,
  input  logic [31:0] wait_time,
  output logic        run_start,
  output logic        run_pause,
  output logic        run_waiting,
  output logic [1:0]  run_speedup,
  output logic [2:0]  state,
  output logic [15:0] trip_cnt,
  output logic        fare_valid,
  output logic [31:0] fare_dis,
  output logic [31:0] fare_wait
);

  import taxi_pkg::*;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  logic start_evt_s, end_evt_s, pause_evt_s, wait_evt_s;

  taxi_state_e state_r, state_nxt_s, pause_src_r, pause_src_nxt_s;
  logic [15:0] settle_cnt_r, settle_cnt_nxt_s;
  logic [15:0] trip_cnt_r, trip_cnt_nxt_s;
  logic        fare_valid_r, fare_valid_nxt_s;
  logic [31:0] fare_dis_r, fare_dis_nxt_s, fare_wait_r, fare_wait_nxt_s;
  logic        run_start_r, run_pause_r, run_waiting_r;
  logic        run_start_nxt_s, run_pause_nxt_s, run_waiting_nxt_s;
  logic [1:0]  run_speedup_r, run_speedup_nxt_s;
  logic        snap_s;

  taxi_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_start (
    .clk(clk), .rst(rst), .btn(btn_start), .evt(start_evt_s));
  taxi_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_end (
    .clk(clk), .rst(rst), .btn(btn_end), .evt(end_evt_s));
  taxi_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_pause (
    .clk(clk), .rst(rst), .btn(btn_pause), .evt(pause_evt_s));
  taxi_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_wait (
    .clk(clk), .rst(rst), .btn(btn_wait), .evt(wait_evt_s));

  // Next-state, snapshot and next-output logic; event priority end > pause > wait > start.
  always_comb begin
    state_nxt_s      = state_r;
    pause_src_nxt_s  = pause_src_r;
    settle_cnt_nxt_s = 16'd0;
    snap_s           = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start_evt_s) state_nxt_s = ST_RUN;
        else             state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (end_evt_s) begin
          state_nxt_s = ST_SETTLE;
          snap_s      = 1'b1;
        end else if (pause_evt_s) begin
          state_nxt_s     = ST_PAUSE;
          pause_src_nxt_s = ST_RUN;
        end else if (wait_evt_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (end_evt_s) begin
          state_nxt_s = ST_SETTLE;
          snap_s      = 1'b1;
        end else if (pause_evt_s) begin
          state_nxt_s     = ST_PAUSE;
          pause_src_nxt_s = ST_WAIT;
        end else if (wait_evt_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_PAUSE: begin
        if (end_evt_s) begin
          state_nxt_s = ST_SETTLE;
          snap_s      = 1'b1;
        end else if (pause_evt_s) begin
          state_nxt_s = pause_src_r;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_SETTLE: begin
        if (start_evt_s) begin
          state_nxt_s = ST_RUN;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s      = ST_SETTLE;
          settle_cnt_nxt_s = settle_cnt_r + 16'd1;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    trip_cnt_nxt_s   = trip_cnt_r;
    fare_valid_nxt_s = fare_valid_r;
    fare_dis_nxt_s   = fare_dis_r;
    fare_wait_nxt_s  = fare_wait_r;
    if (snap_s) begin
      trip_cnt_nxt_s   = trip_cnt_r + 16'd1;
      fare_valid_nxt_s = 1'b1;
      fare_dis_nxt_s   = distance;
      fare_wait_nxt_s  = wait_time;
    end else if (state_nxt_s == ST_RUN) begin
      fare_valid_nxt_s = 1'b0;
    end else begin
      fare_valid_nxt_s = fare_valid_r;
    end

    // Outputs are derived from the next state so they change on the transition edge.
    run_start_nxt_s   = 1'b0;
    run_pause_nxt_s   = 1'b0;
    run_waiting_nxt_s = 1'b0;
    run_speedup_nxt_s = SPEED_NORMAL;
    case (state_nxt_s)
      ST_RUN: begin
        run_start_nxt_s   = 1'b1;
        run_speedup_nxt_s = sat_speed(speed_sel);
      end
      ST_WAIT: begin
        run_start_nxt_s   = 1'b1;
        run_waiting_nxt_s = 1'b1;
      end
      ST_PAUSE: begin
        run_start_nxt_s = 1'b1;
        run_pause_nxt_s = 1'b1;
      end
      default: begin
        run_start_nxt_s = 1'b0;
      end
    endcase
  end

  // State, trip bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      pause_src_r   <= ST_RUN;
      settle_cnt_r  <= 16'd0;
      trip_cnt_r    <= 16'd0;
      fare_valid_r  <= 1'b0;
      fare_dis_r    <= 32'd0;
      fare_wait_r   <= 32'd0;
      run_start_r   <= 1'b0;
      run_pause_r   <= 1'b0;
      run_waiting_r <= 1'b0;
      run_speedup_r <= 2'd0;
    end else begin
      state_r       <= state_nxt_s;
      pause_src_r   <= pause_src_nxt_s;
      settle_cnt_r  <= settle_cnt_nxt_s;
      trip_cnt_r    <= trip_cnt_nxt_s;
      fare_valid_r  <= fare_valid_nxt_s;
      fare_dis_r    <= fare_dis_nxt_s;
      fare_wait_r   <= fare_wait_nxt_s;
      run_start_r   <= run_start_nxt_s;
      run_pause_r   <= run_pause_nxt_s;
      run_waiting_r <= run_waiting_nxt_s;
      run_speedup_r <= run_speedup_nxt_s;
    end
  end

  assign state       = state_r;
  assign trip_cnt    = trip_cnt_r;
  assign fare_valid  = fare_valid_r;
  assign fare_dis    = fare_dis_r;
  assign fare_wait   = fare_wait_r;
  assign run_start   = run_start_r;
  assign run_pause   = run_pause_r;
  assign run_waiting = run_waiting_r;
  assign run_speedup = run_speedup_r;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Directed bench for taxi_trip_ctrl: expectations are queued as stimulus is
// applied and checked against DUT outputs after the corresponding edges.
module tb_taxi_trip_ctrl;

  localparam int DB = 4;
  localparam int SC = 100;

  localparam logic [3:0] M_START = 4'b0001;
  localparam logic [3:0] M_END   = 4'b0010;
  localparam logic [3:0] M_PAUSE = 4'b0100;
  localparam logic [3:0] M_WAIT  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0, btn_end = 1'b0, btn_pause = 1'b0, btn_wait = 1'b0;
  logic [1:0]  speed_sel = 2'd0;
  logic [31:0] distance = 32'd0, wait_time = 32'd0;
  logic        run_start, run_pause, run_waiting, fare_valid;
  logic [1:0]  run_speedup;
  logic [2:0]  state;
  logic [15:0] trip_cnt;
  logic [31:0] fare_dis, fare_wait;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  taxi_trip_ctrl #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_end(btn_end), .btn_pause(btn_pause), .btn_wait(btn_wait),
    .speed_sel(speed_sel), .distance(distance), .wait_time(wait_time),
    .run_start(run_start), .run_pause(run_pause), .run_waiting(run_waiting),
    .run_speedup(run_speedup), .state(state), .trip_cnt(trip_cnt),
    .fare_valid(fare_valid), .fare_dis(fare_dis), .fare_wait(fare_wait));

  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty observed=%0d expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] m);
    btn_start = m[0];
    btn_end   = m[1];
    btn_pause = m[2];
    btn_wait  = m[3];
  endtask

  // Hold the buttons for DB edges, release, then one edge for the FSM to act.
  task automatic press(input logic [3:0] m);
    set_btns(m);
    tick(DB);
    set_btns(4'b0000);
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(2);
    expect_v("rst_state", 32'd0); expect_v("rst_run_start", 32'd0);
    expect_v("rst_trip_cnt", 32'd0); expect_v("rst_fare_valid", 32'd0);
    compare(32'(state)); compare(32'(run_start)); compare(32'(trip_cnt)); compare(32'(fare_valid));
    rst = 1'b1;
    tick(2);

    // Start latency: event at N+DB-1, state change at N+DB
    btn_start = 1'b1;
    expect_v("lat_idle_before", 32'd0);
    tick(DB);
    compare(32'(state));
    expect_v("lat_run", 32'd1); expect_v("lat_run_start", 32'd1);
    tick(1);
    compare(32'(state)); compare(32'(run_start));
    expect_v("start_held_run", 32'd1);
    tick(8);
    compare(32'(state));
    btn_start = 1'b0;

    // Speed class saturation and tracking
    speed_sel = 2'd3;
    expect_v("speedup_sat", 32'd2);
    tick(1);
    compare(32'(run_speedup));
    speed_sel = 2'd1;
    expect_v("speedup_fast", 32'd1);
    tick(1);
    compare(32'(run_speedup));

    // RUN <-> WAIT
    expect_v("wait_state", 32'd2); expect_v("wait_run_waiting", 32'd1); expect_v("wait_speedup", 32'd0);
    press(M_WAIT);
    compare(32'(state)); compare(32'(run_waiting)); compare(32'(run_speedup));
    expect_v("unwait_state", 32'd1); expect_v("unwait_speedup", 32'd1);
    press(M_WAIT);
    compare(32'(state)); compare(32'(run_speedup));

    // A held wait button toggles only once
    btn_wait = 1'b1;
    expect_v("hold_wait_state", 32'd2);
    tick(DB + 1);
    compare(32'(state));
    expect_v("hold_wait_still", 32'd2);
    tick(20);
    compare(32'(state));
    btn_wait = 1'b0;
    tick(1);

    // Pause from WAIT returns to WAIT; wait ignored while paused
    expect_v("pause_state", 32'd3); expect_v("pause_run_pause", 32'd1);
    expect_v("pause_run_start", 32'd1); expect_v("pause_run_waiting", 32'd0);
    press(M_PAUSE);
    compare(32'(state)); compare(32'(run_pause)); compare(32'(run_start)); compare(32'(run_waiting));
    expect_v("pause_ignore_wait", 32'd3);
    press(M_WAIT);
    compare(32'(state));
    expect_v("unpause_to_wait", 32'd2); expect_v("unpause_run_pause", 32'd0);
    press(M_PAUSE);
    compare(32'(state)); compare(32'(run_pause));

    // End of trip snapshot and settle timeout
    press(M_WAIT);
    distance  = 32'd1234;
    wait_time = 32'd56;
    expect_v("end_state", 32'd4); expect_v("end_fare_valid", 32'd1); expect_v("end_fare_dis", 32'd1234);
    expect_v("end_fare_wait", 32'd56); expect_v("end_trip_cnt", 32'd1); expect_v("end_run_start", 32'd0);
    press(M_END);
    compare(32'(state)); compare(32'(fare_valid)); compare(fare_dis);
    compare(fare_wait); compare(32'(trip_cnt)); compare(32'(run_start));
    distance  = 32'd9999;
    expect_v("settle_hold", 32'd4);
    tick(SC - 1);
    compare(32'(state));
    expect_v("settle_idle", 32'd0); expect_v("settle_fare_valid", 32'd1); expect_v("settle_fare_dis", 32'd1234);
    tick(1);
    compare(32'(state)); compare(32'(fare_valid)); compare(fare_dis);

    // New trip clears fare_valid; end and pause together take the end path
    expect_v("new_trip_state", 32'd1); expect_v("new_trip_fare_valid", 32'd0);
    press(M_START);
    compare(32'(state)); compare(32'(fare_valid));
    distance = 32'd777;
    expect_v("coinc_state", 32'd4); expect_v("coinc_run_pause", 32'd0);
    expect_v("coinc_trip_cnt", 32'd2); expect_v("coinc_fare_dis", 32'd777);
    press(M_END | M_PAUSE);
    compare(32'(state)); compare(32'(run_pause)); compare(32'(trip_cnt)); compare(fare_dis);

    // Start inside SETTLE resumes immediately
    expect_v("settle_start_state", 32'd1); expect_v("settle_start_fare_dis", 32'd777);
    press(M_START);
    compare(32'(state)); compare(fare_dis);

    // Trip counter wraps
    force dut.trip_cnt_r = 16'hFFFF;
    #1;
    release dut.trip_cnt_r;
    expect_v("wrap_trip_cnt", 32'd0); expect_v("wrap_state", 32'd4);
    press(M_END);
    compare(32'(trip_cnt)); compare(32'(state));

    // Asynchronous reset during PAUSE, start held across release
    press(M_START);
    press(M_PAUSE);
    btn_start = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    expect_v("arst_state", 32'd0); expect_v("arst_run_start", 32'd0); expect_v("arst_run_pause", 32'd0);
    expect_v("arst_trip_cnt", 32'd0); expect_v("arst_fare_valid", 32'd0); expect_v("arst_fare_dis", 32'd0);
    compare(32'(state)); compare(32'(run_start)); compare(32'(run_pause));
    compare(32'(trip_cnt)); compare(32'(fare_valid)); compare(fare_dis);
    tick(2);
    rst = 1'b1;
    expect_v("held_across_rst", 32'd0);
    tick(12);
    compare(32'(state));
    btn_start = 1'b0;
    tick(1);
    expect_v("repress_state", 32'd1);
    press(M_START);
    compare(32'(state));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
